la_ioringseq: RTL and testbench

LA_IORINGSEQ -- requirements
Module: la_ioringseq

---
 rtl/la_ioringseq.sv | 156 +++++++++++++++
 tb/tb_la_ioringseq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/la_ioringseq.sv
// IO-ring power sequencer: enables ring segments LSB-first on power-up and MSB-first on power-down.
// Each step is spaced by a latched delay, and loss of the synchronized io-supply forces an immediate fault shutdown.
module la_ioringseq #(
   parameter int RINGW = 8,
   parameter int DLYW  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vddio_ok,
   input  logic             en,
   input  logic [DLYW-1:0]  dly,
   output logic [RINGW-1:0] ioring,
   output logic             ready,
   output logic             busy,
   output logic             fault
);

   localparam int IW = $clog2(RINGW + 1);

   typedef enum logic [2:0] {
      S_OFF,
      S_UP,
      S_ON,
      S_DOWN,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync_ok_q;
   logic [DLYW-1:0]  cnt_q, cnt_d;
   logic [DLYW-1:0]  dhold_q, dhold_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [RINGW-1:0] ioring_q, ioring_d;
   logic             ready_q, busy_q, fault_q;
   logic             step;
   logic [RINGW-1:0] up_mask, dn_mask;

   assign step    = (cnt_q == dhold_q);
   assign up_mask = RINGW'(1) << idx_q;
   assign dn_mask = RINGW'(1) << (idx_q - IW'(1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dhold_d  = dhold_q;
      idx_d    = idx_q;
      ioring_d = ioring_q;
      case (state_q)
         S_OFF: begin
            if (en && sync_ok_q) begin
               state_d = S_UP;
               dhold_d = dly;
               cnt_d   = '0;
            end
         end
         S_UP: begin
            if (!sync_ok_q) begin
               state_d  = S_FAULT;
               ioring_d = '0;
               idx_d    = '0;
               cnt_d    = '0;
            end else if (!en) begin
               state_d = S_DOWN;
               dhold_d = dly;
               cnt_d   = '0;
            end else if (step) begin
               ioring_d = ioring_q | up_mask;
               idx_d    = idx_q + IW'(1);
               cnt_d    = '0;
               if (idx_q == IW'(RINGW - 1)) state_d = S_ON;
            end else begin
               cnt_d = cnt_q + DLYW'(1);
            end
         end
         S_ON: begin
            if (!sync_ok_q) begin
               state_d  = S_FAULT;
               ioring_d = '0;
               idx_d    = '0;
               cnt_d    = '0;
            end else if (!en) begin
               state_d = S_DOWN;
               dhold_d = dly;
               cnt_d   = '0;
            end
         end
         S_DOWN: begin
            if (!sync_ok_q) begin
               state_d  = S_FAULT;
               ioring_d = '0;
               idx_d    = '0;
               cnt_d    = '0;
            end else if (en) begin
               // Re-request before any bit was dropped: the ring is already complete.
               if (idx_q == IW'(RINGW)) begin
                  state_d = S_ON;
               end else begin
                  state_d = S_UP;
                  dhold_d = dly;
                  cnt_d   = '0;
               end
            end else if (idx_q == '0) begin
               state_d = S_OFF;
            end else if (step) begin
               ioring_d = ioring_q & ~dn_mask;
               idx_d    = idx_q - IW'(1);
               cnt_d    = '0;
               if (idx_q == IW'(1)) state_d = S_OFF;
            end else begin
               cnt_d = cnt_q + DLYW'(1);
            end
         end
         S_FAULT: begin
            if (!en && sync_ok_q) state_d = S_OFF;
         end
         default: begin
            state_d  = S_OFF;
            ioring_d = '0;
            idx_d    = '0;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_OFF;
         sync1_q   <= 1'b0;
         sync_ok_q <= 1'b0;
         cnt_q     <= '0;
         dhold_q   <= '0;
         idx_q     <= '0;
         ioring_q  <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         sync1_q   <= vddio_ok;
         sync_ok_q <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dhold_q   <= dhold_d;
         idx_q     <= idx_d;
         ioring_q  <= ioring_d;
         ready_q   <= (state_d == S_ON);
         busy_q    <= (state_d == S_UP) || (state_d == S_DOWN);
         fault_q   <= (state_d == S_FAULT);
      end
   end

   assign ioring = ioring_q;
   assign ready  = ready_q;
   assign busy   = busy_q;
   assign fault  = fault_q;

endmodule

// File: tb/tb_la_ioringseq.sv
// Bench for la_ioringseq: directed power-up/down/fault/reset scenarios, then randomized traffic,
// all compared every cycle against a segment-count/elapsed-time reference model.
module tb_la_ioringseq;

   localparam int RINGW = 8;
   localparam int DLYW  = 8;

   localparam int M_OFF   = 0;
   localparam int M_UP    = 1;
   localparam int M_ON    = 2;
   localparam int M_DOWN  = 3;
   localparam int M_FAULT = 4;

   logic             clk = 1'b0;
   logic             rst_r = 1'b1;
   logic             vdd_r = 1'b0;
   logic             en_r = 1'b0;
   logic [DLYW-1:0]  dly_r = '0;
   logic [RINGW-1:0] ioring;
   logic             ready, busy, fault;

   int checks = 0;
   int errors = 0;

   // Reference model: number of lit segments, phase elapsed time, latched delay.
   int m_mode = M_OFF;
   int m_n    = 0;
   int m_t    = 0;
   int m_d    = 0;
   bit m_s1   = 1'b0;
   bit m_s2   = 1'b0;

   la_ioringseq #(.RINGW(RINGW), .DLYW(DLYW)) dut (
      .clk      (clk),
      .reset    (rst_r),
      .vddio_ok (vdd_r),
      .en       (en_r),
      .dly      (dly_r),
      .ioring   (ioring),
      .ready    (ready),
      .busy     (busy),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] model_ring();
      return (32'd1 << m_n) - 32'd1;
   endfunction

   task automatic model_edge();
      bit s;
      s = m_s2;
      if (rst_r) begin
         m_mode = M_OFF; m_n = 0; m_t = 0; m_d = 0; m_s1 = 0; m_s2 = 0;
         return;
      end
      m_s2 = m_s1;
      m_s1 = vdd_r;
      if ((m_mode == M_UP || m_mode == M_ON || m_mode == M_DOWN) && !s) begin
         m_mode = M_FAULT; m_n = 0;
         return;
      end
      case (m_mode)
         M_OFF: if (en_r && s) begin m_mode = M_UP; m_d = int'(dly_r); m_t = 0; end
         M_UP: begin
            if (!en_r) begin
               m_mode = M_DOWN; m_d = int'(dly_r); m_t = 0;
            end else begin
               m_t++;
               if (m_t % (m_d + 1) == 0) begin
                  m_n++;
                  if (m_n == RINGW) m_mode = M_ON;
               end
            end
         end
         M_ON: if (!en_r) begin m_mode = M_DOWN; m_d = int'(dly_r); m_t = 0; end
         M_DOWN: begin
            if (en_r) begin
               if (m_n == RINGW) m_mode = M_ON;
               else begin m_mode = M_UP; m_d = int'(dly_r); m_t = 0; end
            end else if (m_n == 0) begin
               m_mode = M_OFF;
            end else begin
               m_t++;
               if (m_t % (m_d + 1) == 0) begin
                  m_n--;
                  if (m_n == 0) m_mode = M_OFF;
               end
            end
         end
         default: if (!en_r && s) m_mode = M_OFF;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("ioring", 32'(ioring), model_ring());
      chk("ready",  32'(ready),  32'(m_mode == M_ON));
      chk("busy",   32'(busy),   32'(m_mode == M_UP || m_mode == M_DOWN));
      chk("fault",  32'(fault),  32'(m_mode == M_FAULT));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // Reset state
      rst_r = 1; run(2);
      chk("rst_ring", 32'(ioring), 32'h0);
      chk("rst_flags", {29'b0, ready, busy, fault}, 32'h0);

      // Power-up with dly=3; sync needs two cycles after reset
      rst_r = 0; vdd_r = 1; en_r = 1; dly_r = 8'd3;
      run(2); chk("sync_wait_busy", 32'(busy), 32'h0);
      run(1); chk("up_entry_busy", 32'(busy), 32'h1);
      run(4); chk("up_b0", 32'(ioring), 32'h01);
      run(4); chk("up_b1", 32'(ioring), 32'h03);
      run(24); chk("up_full", 32'(ioring), 32'hFF); chk("up_ready", 32'(ready), 32'h1);

      // Power-down with dly=0
      dly_r = 8'd0; en_r = 0;
      run(1); chk("dn_entry", 32'(ioring), 32'hFF); chk("dn_busy", 32'(busy), 32'h1);
      run(1); chk("dn_7f", 32'(ioring), 32'h7F);
      run(6); chk("dn_01", 32'(ioring), 32'h01);
      run(1); chk("dn_off", 32'(ioring), 32'h00); chk("dn_off_busy", 32'(busy), 32'h0);

      // Reversal in mid-sequence with dly=1
      en_r = 1; dly_r = 8'd1;
      run(7); chk("rev_07", 32'(ioring), 32'h07);
      en_r = 0;
      run(1); chk("rev_hold", 32'(ioring), 32'h07);
      run(2); chk("rev_03", 32'(ioring), 32'h03);
      run(2); chk("rev_01", 32'(ioring), 32'h01);
      en_r = 1;
      run(1); chk("rev_up_hold", 32'(ioring), 32'h01);
      run(2); chk("rev_up_03", 32'(ioring), 32'h03);
      run(2); chk("rev_up_07", 32'(ioring), 32'h07);
      run(2); chk("rev_up_0f", 32'(ioring), 32'h0F);

      // Supply loss: fault three edges later, en=1 ignored, en=0 exits
      vdd_r = 0;
      run(2); chk("flt_wait", 32'(fault), 32'h0);
      run(1); chk("flt_set", 32'(fault), 32'h1); chk("flt_ring", 32'(ioring), 32'h0);
      vdd_r = 1; en_r = 1;
      run(4); chk("flt_hold", 32'(fault), 32'h1);
      en_r = 0;
      run(1); chk("flt_clear", 32'(fault), 32'h0);

      // Reset while ON, then long delay with mid-sequence dly change
      en_r = 1; dly_r = 8'd0;
      run(9); chk("on_ready", 32'(ready), 32'h1);
      rst_r = 1;
      run(1); chk("rst_on_ring", 32'(ioring), 32'h0); chk("rst_on_ready", 32'(ready), 32'h0);
      rst_r = 0; dly_r = 8'd255;
      run(2); chk("rst_sync_busy", 32'(busy), 32'h0);
      run(1);
      dly_r = 8'd0;
      run(255); chk("long_pre", 32'(ioring), 32'h00);
      run(1); chk("long_b0", 32'(ioring), 32'h01);
      run(255); chk("long_hold", 32'(ioring), 32'h01);
      run(1); chk("long_b1", 32'(ioring), 32'h03);

      // Randomized traffic
      rst_r = 1; run(1); rst_r = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 24) == 0) en_r = ~en_r;
         if (vdd_r && $urandom_range(0, 149) == 0) vdd_r = 0;
         else if (!vdd_r && $urandom_range(0, 3) == 0) vdd_r = 1;
         dly_r = 8'($urandom_range(0, 3));
         rst_r = ($urandom_range(0, 599) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
